// File: rtl/neuron_accumulator_if.sv
// Accumulate-stream interface: product/bias beats in, finished pre-activation out.
// The master side is the producer of beats and the consumer of results.
interface neuron_accumulator_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [19:0] in_prod;
  logic signed [21:0] bias_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [21:0] out_sum;
  logic signed [21:0] out_relu;
  logic               out_ovf;

  modport master (
    output in_valid, in_prod, bias_in, out_ready,
    input  in_ready, out_valid, out_sum, out_relu, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, bias_in, out_ready,
    output in_ready, out_valid, out_sum, out_relu, out_ovf
  );
endinterface

// File: rtl/neuron_accumulator.sv
// Folds N_TERMS signed products into a bias-seeded 22-bit wrapping sum and holds
// the result (raw, ReLU, sticky overflow) until the downstream stage takes it.
module neuron_accumulator #(
  parameter int N_TERMS = 784
) (
  input  logic clk,
  input  logic rst,
  neuron_accumulator_if.slave bus
);

  localparam int CNT_W = $clog2(N_TERMS + 1);

  typedef enum logic {
    ACC,
    OUT
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic signed [21:0] acc;
  logic               ovf;
  logic signed [21:0] sum_q;
  logic signed [21:0] relu_q;
  logic               ovf_q;

  logic               in_ready_c;
  logic               out_valid_c;
  logic               beat;
  logic               first;
  logic               last;
  logic               handshake;
  logic signed [21:0] prod_ext;
  logic signed [21:0] addend;
  logic signed [21:0] sum;
  logic               add_ovf;
  logic               frame_ovf;

  // The first beat of a frame adds to the bias instead of the running sum,
  // which is what discards the previous frame without an explicit clear.
  assign first     = (cnt == '0);
  assign last      = (cnt == CNT_W'(N_TERMS - 1));
  assign prod_ext  = {{2{bus.in_prod[19]}}, bus.in_prod};
  assign addend    = first ? bus.bias_in : acc;
  assign sum       = addend + prod_ext;
  assign add_ovf   = (addend[21] == prod_ext[21]) && (sum[21] != addend[21]);
  assign frame_ovf = first ? add_ovf : (ovf | add_ovf);

  assign beat      = bus.in_valid && in_ready_c;
  assign handshake = out_valid_c && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACC;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      ACC: begin
        in_ready_c = 1'b1;
        if (beat && last) begin
          state_next = OUT;
        end
      end
      OUT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_next = ACC;
        end
      end
      default: state_next = ACC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      ovf <= 1'b0;
    end else if (beat) begin
      cnt <= cnt + CNT_W'(1);
      acc <= sum;
      ovf <= frame_ovf;
    end else if (handshake) begin
      cnt <= '0;
    end
  end

  // Result registers stay put after the handshake; only the next frame's last
  // beat overwrites them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      relu_q <= '0;
      ovf_q  <= 1'b0;
    end else if (beat && last) begin
      sum_q  <= sum;
      relu_q <= sum[21] ? '0 : sum;
      ovf_q  <= frame_ovf;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_sum   = sum_q;
  assign bus.out_relu  = relu_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Bench for neuron_accumulator: three instances (4, 2 and 1 terms) share one
// stimulus path selected by sel; a frame-level model is compared every cycle.
module tb_neuron_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [19:0] in_prod;
  logic [21:0] bias_in;
  int          sel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  neuron_accumulator_if if4 ();
  neuron_accumulator_if if2 ();
  neuron_accumulator_if if1 ();

  neuron_accumulator #(.N_TERMS(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  neuron_accumulator #(.N_TERMS(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  neuron_accumulator #(.N_TERMS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  assign if4.in_valid  = (sel == 0) && in_valid;
  assign if2.in_valid  = (sel == 1) && in_valid;
  assign if1.in_valid  = (sel == 2) && in_valid;
  assign if4.out_ready = (sel == 0) && out_ready;
  assign if2.out_ready = (sel == 1) && out_ready;
  assign if1.out_ready = (sel == 2) && out_ready;
  assign if4.in_prod   = in_prod;
  assign if2.in_prod   = in_prod;
  assign if1.in_prod   = in_prod;
  assign if4.bias_in   = bias_in;
  assign if2.bias_in   = bias_in;
  assign if1.bias_in   = bias_in;

  logic        d_in_ready, d_out_valid, d_out_ovf;
  logic [21:0] d_out_sum, d_out_relu;

  always_comb begin
    d_in_ready  = if4.in_ready;
    d_out_valid = if4.out_valid;
    d_out_sum   = if4.out_sum;
    d_out_relu  = if4.out_relu;
    d_out_ovf   = if4.out_ovf;
    if (sel == 1) begin
      d_in_ready  = if2.in_ready;
      d_out_valid = if2.out_valid;
      d_out_sum   = if2.out_sum;
      d_out_relu  = if2.out_relu;
      d_out_ovf   = if2.out_ovf;
    end else if (sel == 2) begin
      d_in_ready  = if1.in_ready;
      d_out_valid = if1.out_valid;
      d_out_sum   = if1.out_sum;
      d_out_relu  = if1.out_relu;
      d_out_ovf   = if1.out_ovf;
    end
  end

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got 0x%0h want 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model: collect a frame, then sum it ----------
  int n_of [3] = '{4, 2, 1};
  logic signed [19:0] frame_q [$];
  logic [21:0] frame_bias;
  logic        m_valid;
  logic [21:0] m_sum, m_relu;
  logic        m_ovf;

  function automatic int wrap22(input int v);
    logic signed [21:0] t;
    t = v[21:0];
    return int'(t);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q.delete();
      m_valid = 1'b0;
      m_sum   = '0;
      m_relu  = '0;
      m_ovf   = 1'b0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 1'b0;
    end else if (in_valid) begin
      if (frame_q.size() == 0) frame_bias = bias_in;
      frame_q.push_back(in_prod);
      if (frame_q.size() == n_of[sel]) begin
        int s;
        bit o;
        s = int'(signed'(frame_bias));
        o = 1'b0;
        foreach (frame_q[i]) begin
          s = s + int'(frame_q[i]);
          if (s > 2097151 || s < -2097152) o = 1'b1;
          s = wrap22(s);
        end
        m_sum   = s[21:0];
        m_relu  = (s < 0) ? 22'd0 : s[21:0];
        m_ovf   = o;
        m_valid = 1'b1;
        frame_q.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready",  22'(d_in_ready),  22'(!m_valid));
      check("out_valid", 22'(d_out_valid), 22'(m_valid));
      check("out_sum",   d_out_sum,  m_sum);
      check("out_relu",  d_out_relu, m_relu);
      check("out_ovf",   22'(d_out_ovf), 22'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic cyc(input logic v, input logic [19:0] p, input logic [21:0] b, input logic r);
    in_valid  = v;
    in_prod   = p;
    bias_in   = b;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int s);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_prod   = '0;
    bias_in   = '0;
    sel       = s;
    rst       = 1'b1;
    #12;
    rst       = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_result(input string tag, input logic [21:0] s, input logic [21:0] r,
                               input logic o);
    check({tag, "_valid"}, 22'(d_out_valid), 22'd1);
    check({tag, "_ready"}, 22'(d_in_ready), 22'd0);
    check({tag, "_sum"},   d_out_sum, s);
    check({tag, "_relu"},  d_out_relu, r);
    check({tag, "_ovf"},   22'(d_out_ovf), 22'(o));
  endtask

  task automatic random_run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      logic [21:0] b;
      case ($urandom_range(0, 3))
        0:       b = 22'h1FFFFF;
        1:       b = 22'h200000;
        default: b = 22'($urandom);
      endcase
      cyc($urandom_range(0, 3) != 0, 20'($urandom), b, $urandom_range(0, 2) != 0);
    end
  endtask

  initial begin
    // ---------------- 4-term instance -------------------------------------
    do_reset(0);
    check("rst_valid", 22'(d_out_valid), 22'd0);
    check("rst_sum",   d_out_sum, 22'd0);
    check("rst_ready", 22'(d_in_ready), 22'd1);

    cyc(1, 20'd1, 22'd10, 1);
    cyc(1, 20'd2, 22'd0, 1);
    cyc(1, 20'd3, 22'd0, 1);
    check("pre_last_valid", 22'(d_out_valid), 22'd0);
    cyc(1, 20'd4, 22'd0, 1);
    expect_result("basic", 22'd20, 22'd20, 1'b0);
    cyc(0, 20'd0, 22'd0, 1);
    check("post_hs_ready", 22'(d_in_ready), 22'd1);

    cyc(1, -20'sd100, 22'd0, 0);
    cyc(1, 20'd20, 22'h3FFFFF, 0);
    cyc(1, 20'd30, 22'h3FFFFF, 0);
    cyc(1, -20'sd5, 22'h3FFFFF, 0);
    expect_result("neg", 22'h3FFFC9, 22'd0, 1'b0);
    cyc(0, 20'd0, 22'd0, 1);

    // Backpressure: result held, input beats ignored while out_ready is low.
    cyc(1, 20'd1, 22'd100, 0);
    cyc(1, 20'd2, 22'd0, 0);
    cyc(1, 20'd3, 22'd0, 0);
    cyc(1, 20'd4, 22'd0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 20'($urandom), 22'h55, 0);
    expect_result("hold", 22'd110, 22'd110, 1'b0);
    cyc(0, 20'd0, 22'd0, 1);
    check("release_ready", 22'(d_in_ready), 22'd1);
    cyc(1, 20'd1, 22'd5, 0);
    cyc(1, 20'd1, 22'd0, 0);
    cyc(1, 20'd1, 22'd0, 0);
    cyc(1, 20'd1, 22'd0, 0);
    expect_result("rebias", 22'd9, 22'd9, 1'b0);
    cyc(0, 20'd0, 22'd0, 1);

    // Gapped input.
    cyc(1, 20'd5, 22'd3, 0);
    cyc(0, 20'd0, 22'd0, 0);
    cyc(0, 20'd0, 22'd0, 0);
    cyc(1, 20'd6, 22'd0, 0);
    cyc(0, 20'd0, 22'd0, 0);
    cyc(1, 20'd7, 22'd0, 0);
    check("gap_pre_valid", 22'(d_out_valid), 22'd0);
    cyc(1, 20'd8, 22'd0, 0);
    expect_result("gap", 22'd29, 22'd29, 1'b0);
    cyc(0, 20'd0, 22'd0, 1);

    // Asynchronous reset after two beats of a frame.
    cyc(1, 20'd50, 22'd40, 0);
    cyc(1, 20'd60, 22'd0, 0);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst_valid", 22'(d_out_valid), 22'd0);
    check("arst_sum",   d_out_sum, 22'd0);
    check("arst_relu",  d_out_relu, 22'd0);
    check("arst_ready", 22'(d_in_ready), 22'd1);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, 20'd1, 22'd7, 0);
    cyc(1, 20'd1, 22'd0, 0);
    cyc(1, 20'd1, 22'd0, 0);
    cyc(1, 20'd1, 22'd0, 0);
    expect_result("after_rst", 22'd11, 22'd11, 1'b0);
    cyc(0, 20'd0, 22'd0, 1);
    random_run(400);

    // ---------------- 2-term instance: overflow is sticky per frame --------
    do_reset(1);
    cyc(1, 20'd1, 22'h1FFFFF, 0);
    cyc(1, 20'd0, 22'd0, 0);
    expect_result("ovf", 22'h200000, 22'd0, 1'b1);
    cyc(0, 20'd0, 22'd0, 1);
    cyc(1, 20'd1, 22'd0, 0);
    cyc(1, 20'd1, 22'h1FFFFF, 0);
    expect_result("ovf_clear", 22'd2, 22'd2, 1'b0);
    cyc(0, 20'd0, 22'd0, 1);
    random_run(400);

    // ---------------- 1-term instance: every beat is a whole frame ---------
    do_reset(2);
    cyc(1, 20'd1, -22'sd3, 0);
    expect_result("single", 22'h3FFFFE, 22'd0, 1'b0);
    cyc(0, 20'd0, 22'd0, 1);
    check("single_ready", 22'(d_in_ready), 22'd1);
    random_run(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neuron_accumulator.md
Name: neuron_accumulator

Overview:
- Sequential accumulation engine that drives the 22-bit signed adder datapath of one neuron: consumes a stream of 20-bit signed weight×pixel products, folds them into a 22-bit running sum seeded with a bias, and presents the finished pre-activation and ReLU result downstream.
- Sits between the multiplier stage and the activation/argmax stage of the digit-recognition network. It is the producing/consuming end of the "A + B -> O" accumulate interface (A = product, B = running sum).

Parameters:
- N_TERMS, 784, number of products accumulated per neuron evaluation (28×28 input); legal range 1..65535.
- CNT_W, $clog2(N_TERMS+1), term counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  product/bias beat valid.
- in_ready  output  1  block can accept a beat.
- in_prod  input  20  signed product term.
- bias_in  input  22  signed bias; sampled only on the first beat of a frame.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  22  signed raw accumulated sum (bias + all products).
- out_relu  output  22  out_sum if non-negative, else 0.
- out_ovf  output  1  sticky: at least one signed overflow occurred in this frame.

Behaviour:
- Reset (async, immediate):
  - state=ACC, cnt=0, acc=0, ovf=0.
  - out_valid=0, out_sum=0, out_relu=0, out_ovf=0.
  - in_ready is combinationally 1 in ACC.
- States: ACC, OUT.
- ACC:
  - in_ready=1, out_valid=0.
  - An accepted beat is in_valid && in_ready.
  - With cnt==0: acc <= bias_in + sext22(in_prod), and ovf is set to this add's overflow (it replaces the previous value).
  - With cnt>0: acc <= acc + sext22(in_prod), and ovf |= this add's overflow.
  - cnt increments on each accepted beat.
  - On the beat accepted with cnt==N_TERMS-1:
    - next state OUT;
    - out_sum, out_relu and out_ovf are registered from the final acc/ovf values;
    - out_valid=1 on the following cycle (latency: 1 clock after the last beat).
  - in_valid low: hold all state, no bubble penalty.
- OUT:
  - in_ready=0 and the input is ignored.
  - out_valid=1; outputs held stable until out_ready=1.
  - On out_valid && out_ready: next state ACC, cnt=0, out_valid=0 the next cycle.
  - Output registers keep their last values after the handshake.
  - No same-cycle input acceptance during OUT (minimum 1 idle input cycle per frame).
- Arithmetic:
  - in_prod is sign-extended to 22 bits.
  - The sum wraps modulo 2^22 (two's complement), bit-identical to a 22-bit signed adder.
  - Overflow for one add = operands have equal sign bits and the result sign differs.
- out_relu = out_sum[21] ? 0 : out_sum.
- N_TERMS=1: a single beat computes bias+prod and goes straight to OUT.
- Reset asserted mid-frame or during OUT: the partial sum is discarded and the block returns to reset values. The next accepted beat is treated as a first beat (bias sampled).
- bias_in is a don't-care on beats other than the first of a frame.

Test Plan:
- N_TERMS=4, bias=10, prods 1,2,3,4 with in_valid held high, out_ready=1 -> out_valid high exactly 1 cycle after the 4th beat, out_sum=20, out_relu=20, out_ovf=0, in_ready low that cycle.
- N_TERMS=4, bias=0, prods −100,20,30,−5 -> out_sum=−55 (0x3FFFC9), out_relu=0, out_ovf=0.
- N_TERMS=2, bias=0x1FFFFF (2097151), prods 1,0 -> out_sum=0x200000 (−2097152), out_ovf=1. The next frame with bias=0, prods 1,1 -> out_ovf=0 (sticky cleared per frame).
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid, out_sum and in_ready=0 held stable, in_valid beats are ignored. Releasing out_ready -> in_ready=1 the next cycle, cnt restarts and the new bias is sampled.
- Gapped input: in_valid toggled 1,0,0,1,0,1,1 over a 4-term frame -> the result equals the ungapped sum and out_valid follows the 4th accepted beat by 1 cycle.
- rst pulsed (not clock-aligned) after 2 of 4 beats -> all outputs 0 immediately. A fresh 4-beat frame with bias=7, prods 1,1,1,1 -> out_sum=11.
